// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Word-scaled branch offset added to the branch's PC+4, wrapping mod 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [31:0] imm);
    return pc4 + (imm << 2);
  endfunction

endpackage

// File: rtl/mips_pc_next.sv
// Combinational next-PC selection: taken branch beats stall beats sequential.
module mips_pc_next
  import mips_fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_pc4_i,
  input  logic [31:0] br_imm_i,
  input  logic        stall_i,
  output logic [31:0] pc_next_o,
  output logic [31:0] pc_plus4_o
);

  logic [31:0] target;

  assign pc_plus4_o = pc_i + PC_STEP;
  assign target     = branch_target(br_pc4_i, br_imm_i);

  always_comb begin
    pc_next_o = pc_plus4_o;
    if (br_taken_i)   pc_next_o = target;
    else if (stall_i) pc_next_o = pc_i;
  end

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS fetch stage: PC, BOOT/RUN sequencing and the IF/ID register.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module mips_fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [31:0]        br_pc4,
  input  logic [31:0]        br_imm,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_instr,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
);

  fetch_state_t state_q;
  logic [31:0]  pc_q, pc_d, pc_plus4;
  logic [31:0]  instr_q, pc4_q;
  logic         valid_q;

  mips_pc_next u_pc_next (
    .pc_i       (pc_q),
    .br_taken_i (br_taken),
    .br_pc4_i   (br_pc4),
    .br_imm_i   (br_imm),
    .stall_i    (stall),
    .pc_next_o  (pc_d),
    .pc_plus4_o (pc_plus4)
  );

  // Memory index drops the byte offset and aliases above the memory depth.
  assign imem_addr = pc_q[IMEM_AW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          pc_q <= pc_d;
          if (br_taken) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
          end else if (!stall) begin
            instr_q <= imem_instr;
            pc4_q   <= pc_plus4;
            valid_q <= 1'b1;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else if (state_q == RUN) begin
      if (!br_taken && !stall) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (!br_taken && stall)  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign fetch_cnt = 32'h0;
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Scoreboard bench for mips_fetch_stage: one instance at RESET_PC=0 and one
// at RESET_PC=32'hFFFF_FFFC for the wrap case.
module tb_mips_fetch_stage;
  import mips_fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst2, stall, br_taken;
  logic [31:0] br_pc4, br_imm;
  logic [4:0]  addr1, addr2;
  logic [31:0] instr1, pc41, fc1, sc1, imem1;
  logic [31:0] instr2, pc42, fc2, sc2, imem2;
  logic        v1, v2;
  logic        zero = 1'b0;
  logic [31:0] zero32 = 32'h0;
  logic [31:0] mem [32];

  function automatic logic [31:0] W(input int i);
    if (i == 0)  return 32'h3408_1466;
    if (i == 31) return 32'hDEAD_BEEF;
    return 32'h2000_0000 | i;
  endfunction

  initial for (int i = 0; i < 32; i++) mem[i] = W(i);
  assign imem1 = mem[addr1];
  assign imem2 = mem[addr2];

  mips_fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
    .br_pc4(br_pc4), .br_imm(br_imm), .imem_addr(addr1), .imem_instr(imem1),
    .if_id_instr(instr1), .if_id_pc4(pc41), .if_id_valid(v1),
    .fetch_cnt(fc1), .stall_cnt(sc1));

  mips_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_AW(5)) dut_wrap (
    .clk(clk), .rst(rst2), .stall(zero), .br_taken(zero),
    .br_pc4(zero32), .br_imm(zero32), .imem_addr(addr2), .imem_instr(imem2),
    .if_id_instr(instr2), .if_id_pc4(pc42), .if_id_valid(v2),
    .fetch_cnt(fc2), .stall_cnt(sc2));

  typedef struct {
    int          which;
    string       tag;
    logic [4:0]  addr;
    logic [31:0] instr, pc4;
    logic        valid;
    logic [31:0] fc, sc;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic push(input int w, input string tag, input logic [4:0] a,
                      input logic [31:0] i, input logic [31:0] p, input logic v,
                      input logic [31:0] f, input logic [31:0] s);
    exp_t e;
    e.which = w; e.tag = tag; e.addr = a; e.instr = i; e.pc4 = p;
    e.valid = v; e.fc = f; e.sc = s;
    q.push_back(e);
  endtask

  // One clock: drive inputs (just after a negedge), take the edge, queue the
  // expected post-edge state, then return on the negedge where it is checked.
  task automatic cyc(input int w, input string tag, input logic s, input logic b,
                     input logic [31:0] p4, input logic [31:0] imm,
                     input logic [4:0] a, input logic [31:0] i, input logic [31:0] p,
                     input logic v, input logic [31:0] f, input logic [31:0] sc);
    stall = s; br_taken = b; br_pc4 = p4; br_imm = imm;
    @(posedge clk);
    push(w, tag, a, i, p, v, f, sc);
    @(negedge clk);
  endtask

  // Monitor: compares each queued expectation against the DUT on a negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.which == 0) begin
          chk({e.tag, ".addr"},  {27'h0, addr1}, {27'h0, e.addr});
          chk({e.tag, ".instr"}, instr1, e.instr);
          chk({e.tag, ".pc4"},   pc41, e.pc4);
          chk({e.tag, ".valid"}, {31'h0, v1}, {31'h0, e.valid});
`ifdef FETCH_PERF_CNT_EN
          chk({e.tag, ".fcnt"},  fc1, e.fc);
          chk({e.tag, ".scnt"},  sc1, e.sc);
`else
          chk({e.tag, ".fcnt"},  fc1, 32'h0);
          chk({e.tag, ".scnt"},  sc1, 32'h0);
`endif
        end else begin
          chk({e.tag, ".addr"},  {27'h0, addr2}, {27'h0, e.addr});
          chk({e.tag, ".instr"}, instr2, e.instr);
          chk({e.tag, ".pc4"},   pc42, e.pc4);
          chk({e.tag, ".valid"}, {31'h0, v2}, {31'h0, e.valid});
`ifdef FETCH_PERF_CNT_EN
          chk({e.tag, ".fcnt"},  fc2, e.fc);
`else
          chk({e.tag, ".fcnt"},  fc2, 32'h0);
`endif
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1; stall = 1'b0; br_taken = 1'b0;
    br_pc4 = 32'h0; br_imm = 32'h0;
    #1 push(0, "rst0", 5'd0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, "boot0", 0, 0, 0, 0, 5'd0, 32'h0, 32'd0, 1'b0, 32'd0, 32'd0);
    cyc(0, "run0a", 0, 0, 0, 0, 5'd1, 32'h3408_1466, 32'd4, 1'b1, 32'd1, 32'd0);
    cyc(0, "run0b", 0, 0, 0, 0, 5'd2, W(1), 32'd8, 1'b1, 32'd2, 32'd0);

    // Mid-run reset clears outputs without waiting for a clock edge.
    #2 rst = 1'b1;
    #1 push(0, "rstmid", 5'd0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // BOOT ignores both stall and a branch request.
    cyc(0, "boot1", 1, 1, 32'd100, 32'd7, 5'd0, 32'h0, 32'd0, 1'b0, 32'd0, 32'd0);
    cyc(0, "seq1", 0, 0, 0, 0, 5'd1, 32'h3408_1466, 32'd4,  1'b1, 32'd1, 32'd0);
    cyc(0, "seq2", 0, 0, 0, 0, 5'd2, W(1),          32'd8,  1'b1, 32'd2, 32'd0);
    cyc(0, "seq3", 0, 0, 0, 0, 5'd3, W(2),          32'd12, 1'b1, 32'd3, 32'd0);
    cyc(0, "seq4", 0, 0, 0, 0, 5'd4, W(3),          32'd16, 1'b1, 32'd4, 32'd0);

    cyc(0, "br",   0, 1, 32'd8, 32'hFFFF_FFFE, 5'd0, 32'h0, 32'd16, 1'b0, 32'd4, 32'd0);
    cyc(0, "rr1",  0, 0, 0, 0, 5'd1, 32'h3408_1466, 32'd4, 1'b1, 32'd5, 32'd0);
    cyc(0, "rr2",  0, 0, 0, 0, 5'd2, W(1),          32'd8, 1'b1, 32'd6, 32'd0);

    cyc(0, "stl1", 1, 0, 0, 0, 5'd2, W(1), 32'd8, 1'b1, 32'd6, 32'd1);
    cyc(0, "stl2", 1, 0, 0, 0, 5'd2, W(1), 32'd8, 1'b1, 32'd6, 32'd2);
    cyc(0, "stl3", 1, 0, 0, 0, 5'd2, W(1), 32'd8, 1'b1, 32'd6, 32'd3);

    cyc(0, "brstl", 1, 1, 32'd4,  32'd3, 5'd4,  32'h0, 32'd8, 1'b0, 32'd6, 32'd3);
    cyc(0, "brb1",  0, 1, 32'd0,  32'd5, 5'd5,  32'h0, 32'd8, 1'b0, 32'd6, 32'd3);
    cyc(0, "brb2",  0, 1, 32'd40, 32'd1, 5'd11, 32'h0, 32'd8, 1'b0, 32'd6, 32'd3);
    cyc(0, "afterb", 0, 0, 0, 0, 5'd12, W(11), 32'd48, 1'b1, 32'd7, 32'd3);

    // Target 128 aliases to word 0 of a 32-word memory.
    cyc(0, "alias", 0, 1, 32'd128, 32'd0, 5'd0, 32'h0, 32'd48, 1'b0, 32'd7, 32'd3);
    cyc(0, "aliasr", 0, 0, 0, 0, 5'd1, 32'h3408_1466, 32'd132, 1'b1, 32'd8, 32'd3);

    // Wrap instance: PC starts at 0xFFFF_FFFC (word 31) and rolls to 0.
    push(1, "wrst", 5'd31, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst2 = 1'b0;
    cyc(1, "wboot", 0, 0, 0, 0, 5'd31, 32'h0, 32'd0, 1'b0, 32'd0, 32'd0);
    cyc(1, "wrun1", 0, 0, 0, 0, 5'd0, 32'hDEAD_BEEF, 32'd0, 1'b1, 32'd1, 32'd0);
    cyc(1, "wrun2", 0, 0, 0, 0, 5'd1, 32'h3408_1466, 32'd4, 1'b1, 32'd2, 32'd0);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
